mxint_block_normalizer: RTL

//  Consumer end of the MxInt accumulation path: takes one wide MxInt block (wide mantissas, shared wide exponent)
//  as produced by accumulation and renormalises it to a narrow MxInt format for the next layer.

---
 rtl/mxint_block_normalizer_if.sv | 14 +
 rtl/mxint_block_normalizer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mxint_block_normalizer_if.sv
// MxInt block stream: BLOCK mantissas plus one shared exponent, valid/ready handshake.
interface mxint_block_normalizer_if #(
  parameter int BLOCK = 4,
  parameter int MW    = 16,
  parameter int EW    = 6
);
  logic [BLOCK-1:0][MW-1:0] mdata;
  logic [EW-1:0]            edata;
  logic                     valid;
  logic                     ready;

  modport master (output mdata, edata, valid, input  ready);
  modport slave  (input  mdata, edata, valid, output ready);
endinterface

// File: rtl/mxint_block_normalizer.sv
// Renormalises a wide MxInt block to a narrow one: strip common sign bits, round,
// rebias/clamp the shared exponent. Two stallable register stages, full throughput.
module mxint_block_normalizer #(
  parameter int BLOCK_SIZE             = 4,
  parameter int DATA_IN_0_PRECISION_0  = 16,
  parameter int DATA_IN_0_PRECISION_1  = 6,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  mxint_block_normalizer_if.slave  data_in_0,
  mxint_block_normalizer_if.master data_out_0
);
  localparam int MI   = DATA_IN_0_PRECISION_0;
  localparam int EI   = DATA_IN_0_PRECISION_1;
  localparam int MO   = DATA_OUT_0_PRECISION_0;
  localparam int EO   = DATA_OUT_0_PRECISION_1;
  localparam int CW   = $clog2(MI);
  localparam int EW   = ((EI > EO) ? EI : EO) + CW + 2;
  localparam int EIB  = 2**(EI-1) - 1;
  localparam int EOB  = 2**(EO-1) - 1;

  logic [2:1]                       r_vld_pipe;
  logic [BLOCK_SIZE-1:0][MI-1:0]    r_m1;
  logic [EI-1:0]                    r_e1;
  logic [CW-1:0]                    r_s1;
  logic [BLOCK_SIZE-1:0][MO-1:0]    r_mo;
  logic [EO-1:0]                    r_eo;

  logic [2:1]                       w_rdy;
  logic [BLOCK_SIZE-1:0][CW-1:0]    w_rsb;
  logic [BLOCK_SIZE-1:0][MO-1:0]    w_q;
  logic [CW-1:0]                    w_s;
  logic signed [EW-1:0]             w_e;
  logic                             w_zero, w_uf, w_ovf, w_kill;
  logic [EO-1:0]                    w_eo;

  assign w_rdy[2] = !r_vld_pipe[2] || data_out_0.ready;
  assign w_rdy[1] = !r_vld_pipe[1] || w_rdy[2];

  always_comb begin
    w_s = CW'(MI-1);
    for (int i = 0; i < BLOCK_SIZE; i++)
      if (w_rsb[i] < w_s) w_s = w_rsb[i];
  end

  // Exponent kept wide and signed so both under- and overflow are visible before clamping.
  assign w_e    = EW'(r_e1) - EW'(EIB) - EW'(r_s1) + EW'(EOB);
  assign w_zero = (r_m1 == '0);
  assign w_uf   = w_e[EW-1];
  assign w_ovf  = !w_uf && (w_e[EW-2:0] > (EW-1)'(2**EO-1));
  assign w_kill = w_zero || w_uf;
  assign w_eo   = w_kill ? '0 : (w_ovf ? '1 : w_e[EO-1:0]);

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
    mxint_bn_lane #(.MI(MI), .MO(MO), .CW(CW)) u_lane (
      .i_m_s1 (data_in_0.mdata[g]),
      .o_rsb  (w_rsb[g]),
      .i_m_s2 (r_m1[g]),
      .i_s    (r_s1),
      .i_ovf  (w_ovf),
      .i_kill (w_kill),
      .o_q    (w_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_m1       <= '0;
      r_e1       <= '0;
      r_s1       <= '0;
      r_mo       <= '0;
      r_eo       <= '0;
    end else begin
      if (w_rdy[1]) begin
        r_vld_pipe[1] <= data_in_0.valid;
        if (data_in_0.valid) begin
          r_m1 <= data_in_0.mdata;
          r_e1 <= data_in_0.edata;
          r_s1 <= w_s;
        end
      end
      if (w_rdy[2]) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) begin
          r_mo <= w_q;
          r_eo <= w_eo;
        end
      end
    end
  end

  assign data_in_0.ready  = w_rdy[1];
  assign data_out_0.valid = r_vld_pipe[2];
  assign data_out_0.mdata = r_mo;
  assign data_out_0.edata = r_eo;
endmodule

// Per-mantissa datapath: redundant-sign count (stage 1) and shift/round/saturate (stage 2).
module mxint_bn_lane #(
  parameter int MI = 16,
  parameter int MO = 8,
  parameter int CW = 4
) (
  input  logic [MI-1:0] i_m_s1,
  output logic [CW-1:0] o_rsb,
  input  logic [MI-1:0] i_m_s2,
  input  logic [CW-1:0] i_s,
  input  logic          i_ovf,
  input  logic          i_kill,
  output logic [MO-1:0] o_q
);
  localparam int DROP = MI - MO;
  localparam logic signed [MO:0] QMAX = {2'b00, {(MO-1){1'b1}}};
  localparam logic signed [MO:0] QMIN = {2'b11, {(MO-1){1'b0}}};

  logic [MI-1:0]        w_t;
  logic [MI:0]          w_sum;
  logic signed [MO:0]   w_q;

  always_comb begin : p_rsb
    logic run;
    run   = 1'b1;
    o_rsb = '0;
    for (int j = MI-2; j >= 0; j--) begin
      if (run && (i_m_s1[j] == i_m_s1[MI-1])) o_rsb = o_rsb + CW'(1);
      else run = 1'b0;
    end
  end

  // Shift cannot overflow: block shift is the minimum redundant-sign count.
  assign w_t   = i_m_s2 << i_s;
  assign w_sum = {w_t[MI-1], w_t} + (MI+1)'(2**(DROP-1));
  assign w_q   = w_sum[MI:DROP];

  always_comb begin
    o_q = (w_q > QMAX) ? QMAX[MO-1:0] : w_q[MO-1:0];
    if (i_ovf) o_q = (w_q > 0) ? QMAX[MO-1:0] : ((w_q < 0) ? QMIN[MO-1:0] : '0);
    if (i_kill) o_q = '0;
  end
endmodule
